// File: rtl/nibble_serial_comparator_pkg.sv
// rtl/nibble_serial_comparator_pkg.sv - shared state, cascade encodings and helpers
package nibble_serial_comparator_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_e;

   // Cascade vectors are packed as {ALB, AGB, AEB}
   localparam int CASC_ALB_BIT = 2;
   localparam int CASC_AGB_BIT = 1;
   localparam int CASC_AEB_BIT = 0;

   localparam logic [2:0] CASC_EQ = 3'b001;
   localparam logic [2:0] CASC_LT = 3'b100;
   localparam logic [2:0] CASC_GT = 3'b010;

   function automatic logic casc_is_one_hot(input logic [2:0] c);
      return (c == CASC_EQ) || (c == CASC_LT) || (c == CASC_GT);
   endfunction

endpackage

// File: rtl/nibble_serial_comparator_mag4_slice.sv
// rtl/nibble_serial_comparator_mag4_slice.sv - combinational 4-bit magnitude compare slice
module mag4_slice
   import nibble_serial_comparator_pkg::*;
(
   input  logic [3:0] an_i,
   input  logic [3:0] bn_i,
   input  logic [2:0] casc_i,
   output logic [2:0] casc_o
);

   // Equal nibbles forward the cascade untouched, even non-one-hot patterns
   always_comb begin
      casc_o = casc_i;
      if (an_i > bn_i) begin
         casc_o = CASC_GT;
      end else if (an_i < bn_i) begin
         casc_o = CASC_LT;
      end
   end

endmodule

// File: rtl/nibble_serial_comparator.sv
// rtl/nibble_serial_comparator.sv - serial WIDTH-bit comparator, one nibble per cycle, LSB first
// Optional cascade-input one-hot check built when CASCADE_CHECK_EN is defined.
module nibble_serial_comparator
   import nibble_serial_comparator_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             START,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             ALBi,
   input  logic             AGBi,
   input  logic             AEBi,
   output logic             BUSY,
   output logic             DONE,
   output logic             ALBo,
   output logic             AGBo,
   output logic             AEBo,
   output logic             CERR
);

   localparam int NIBBLES = WIDTH / 4;
   localparam int CNT_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic [2:0]       casc_q, casc_d;
   logic [2:0]       res_q, res_d;
   logic             done_q, done_d;

   logic [3:0]       an, bn;
   logic [2:0]       slice_out;
   logic             start_acc, last_nib;

   assign start_acc = (state_q == IDLE) && START;
   assign last_nib  = (cnt_q == CNT_W'(NIBBLES - 1));

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (START) state_d = RUN;
         RUN:     if (last_nib) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      BUSY = (state_q == RUN);
      DONE = done_q;
      ALBo = res_q[CASC_ALB_BIT];
      AGBo = res_q[CASC_AGB_BIT];
      AEBo = res_q[CASC_AEB_BIT];
   end

   // Constant-index mux keeps the nibble select free of variable shifts
   always_comb begin
      an = 4'h0;
      bn = 4'h0;
      for (int i = 0; i < NIBBLES; i++) begin
         if (cnt_q == CNT_W'(i)) begin
            an = a_q[4*i +: 4];
            bn = b_q[4*i +: 4];
         end
      end
   end

   mag4_slice u_slice (
      .an_i   (an),
      .bn_i   (bn),
      .casc_i (casc_q),
      .casc_o (slice_out)
   );

   always_comb begin
      cnt_d  = cnt_q;
      a_d    = a_q;
      b_d    = b_q;
      casc_d = casc_q;
      res_d  = res_q;
      done_d = 1'b0;
      if (start_acc) begin
         a_d    = A;
         b_d    = B;
         casc_d = {ALBi, AGBi, AEBi};
         cnt_d  = '0;
      end else if (state_q == RUN) begin
         casc_d = slice_out;
         cnt_d  = cnt_q + CNT_W'(1);
         if (last_nib) begin
            res_d  = slice_out;
            done_d = 1'b1;
            cnt_d  = '0;
         end
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt_q  <= '0;
         a_q    <= '0;
         b_q    <= '0;
         casc_q <= '0;
         res_q  <= '0;
         done_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         a_q    <= a_d;
         b_q    <= b_d;
         casc_q <= casc_d;
         res_q  <= res_d;
         done_q <= done_d;
      end
   end

`ifdef CASCADE_CHECK_EN
   logic err_q, cerr_q;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         err_q  <= 1'b0;
         cerr_q <= 1'b0;
      end else begin
         if (start_acc) begin
            err_q <= !casc_is_one_hot({ALBi, AGBi, AEBi});
         end
         if ((state_q == RUN) && last_nib) begin
            cerr_q <= err_q;
         end
      end
   end

   assign CERR = cerr_q;
`else
   assign CERR = 1'b0;
`endif

endmodule

// File: tb/tb_nibble_serial_comparator.sv
// tb/tb_nibble_serial_comparator.sv - directed self-checking bench for nibble_serial_comparator
module tb_nibble_serial_comparator;

   localparam int WIDTH = 16;
`ifdef CASCADE_CHECK_EN
   localparam logic CHK = 1'b1;
`else
   localparam logic CHK = 1'b0;
`endif

   logic             CLK = 1'b0;
   logic             RST = 1'b1;
   logic             START = 1'b0;
   logic [WIDTH-1:0] A = '0;
   logic [WIDTH-1:0] B = '0;
   logic             ALBi = 1'b0, AGBi = 1'b0, AEBi = 1'b0;
   logic             BUSY, DONE, ALBo, AGBo, AEBo, CERR;

   int n_checks = 0;
   int n_fail   = 0;

   nibble_serial_comparator #(.WIDTH(WIDTH)) dut (
      .CLK   (CLK),
      .RST   (RST),
      .START (START),
      .A     (A),
      .B     (B),
      .ALBi  (ALBi),
      .AGBi  (AGBi),
      .AEBi  (AEBi),
      .BUSY  (BUSY),
      .DONE  (DONE),
      .ALBo  (ALBo),
      .AGBo  (AGBo),
      .AEBo  (AEBo),
      .CERR  (CERR)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   // Called #1 after an edge; returns with DONE observed (or bound expired), #1 after that edge
   task automatic compare(input string tag, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] casc, input logic [2:0] exp_res, input logic exp_cerr);
      int cyc;
      int busy_cnt;
      A = a;
      B = b;
      {ALBi, AGBi, AEBi} = casc;
      START = 1'b1;
      tick();
      START = 1'b0;
      A = ~a;
      B = ~b;
      {ALBi, AGBi, AEBi} = ~casc;
      busy_cnt = BUSY ? 1 : 0;
      cyc = 0;
      do begin
         tick();
         cyc++;
         if (!DONE && BUSY) busy_cnt++;
      end while (!DONE && cyc < 20);
      check({tag, "_lat"}, cyc, 4);
      check({tag, "_busy"}, busy_cnt, 4);
      check({tag, "_res"}, {ALBo, AGBo, AEBo}, exp_res);
      check({tag, "_cerr"}, CERR, exp_cerr);
   endtask

   initial begin
      int cyc;
      int dones;

      #12;
      check("reset_outs", {BUSY, DONE, ALBo, AGBo, AEBo, CERR}, 6'b0);
      RST = 1'b0;
      tick();
      check("idle_outs", {BUSY, DONE, ALBo, AGBo, AEBo, CERR}, 6'b0);

      compare("eq1234", 16'h1234, 16'h1234, 3'b001, 3'b001, 1'b0);
      tick();
      check("done_pulse", DONE, 1'b0);
      check("hold_res", {ALBo, AGBo, AEBo}, 3'b001);

      compare("gt8000", 16'h8000, 16'h7FFF, 3'b001, 3'b010, 1'b0);
      compare("beef_lt", 16'hBEEF, 16'hBEEF, 3'b100, 3'b100, 1'b0);
      compare("lsb_ovr", 16'h0001, 16'h0000, 3'b100, 3'b010, 1'b0);
      tick();

      // START during RUN: second request (which would be GT) must be dropped
      A = 16'h0005; B = 16'h0009; {ALBi, AGBi, AEBi} = 3'b001;
      START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      A = 16'hFFFF; B = 16'h0000; START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      check("rstart_busy", BUSY, 1'b1);
      tick();
      check("rstart_done", DONE, 1'b1);
      check("rstart_res", {ALBo, AGBo, AEBo}, 3'b100);
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (DONE || BUSY) dones++;
      end
      check("rstart_noq", dones, 0);

      // START presented in the DONE cycle is accepted back-to-back
      compare("b2b_a", 16'h00F0, 16'h0F00, 3'b001, 3'b100, 1'b0);
      check("b2b_done_at_start", DONE, 1'b1);
      compare("b2b_b", 16'hA5A5, 16'hA5A4, 3'b001, 3'b010, 1'b0);

      // Asynchronous reset two cycles into RUN
      A = 16'h1111; B = 16'h2222; {ALBi, AGBi, AEBi} = 3'b001;
      START = 1'b1;
      tick();
      START = 1'b0;
      tick();
      RST = 1'b1;
      #1;
      check("mid_rst_outs", {BUSY, DONE, ALBo, AGBo, AEBo, CERR}, 6'b0);
      #2;
      RST = 1'b0;
      dones = 0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (DONE || BUSY) dones++;
      end
      check("mid_rst_nodone", dones, 0);
      compare("post_rst", 16'h1111, 16'h2222, 3'b001, 3'b100, 1'b0);

      // Non-one-hot cascade with equal operands passes straight through
      compare("casc110", 16'h4242, 16'h4242, 3'b110, 3'b110, CHK);
      tick();
      check("cerr_hold", CERR, CHK);
      compare("casc_ok", 16'h4242, 16'h4242, 3'b001, 3'b001, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #50000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
